// File: rtl/window_scan_sequencer.sv
// Sliding-window scan sequencer: walks x/y/scale in CORES-wide batches and issues resultStore starts.
// Optional SCAN_PERF_CNT_EN macro adds a saturating batch_count output.
module window_scan_sequencer #(
   parameter int unsigned CORES      = 32,
   parameter int unsigned ROW_BITS   = 10,
   parameter int unsigned COL_BITS   = 10,
   parameter int unsigned SCALE_BITS = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cmd_start,
   input  logic                  cmd_abort,
   input  logic [ROW_BITS-1:0]   img_width,
   input  logic [COL_BITS-1:0]   img_height,
   input  logic [SCALE_BITS-1:0] num_scales,
   output logic                  busy,
   output logic                  done,
   input  logic                  rs_ready,
   output logic                  rs_start,
   output logic                  rs_exit,
   output logic [ROW_BITS-1:0]   rs_startX,
   output logic [COL_BITS-1:0]   rs_startY,
   output logic [SCALE_BITS-1:0] rs_scale
`ifdef SCAN_PERF_CNT_EN
   ,
   output logic [31:0]           batch_count
`endif
);

   localparam int unsigned XW = ROW_BITS + 1;
   localparam int unsigned YW = COL_BITS + 1;
   localparam int unsigned SW = SCALE_BITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EXIT,
      EXIT_WAIT,
      DONE
   } state_t;

   state_t                state, state_nxt;
   logic [ROW_BITS-1:0]   x_q, x_nxt;
   logic [COL_BITS-1:0]   y_q, y_nxt;
   logic [SCALE_BITS-1:0] s_q, s_nxt;
   logic [ROW_BITS-1:0]   w_q, w_nxt;
   logic [COL_BITS-1:0]   h_q, h_nxt;
   logic [SCALE_BITS-1:0] n_q, n_nxt;
   logic                  abort_q, abort_nxt;
   logic                  start_nxt, exit_nxt;
   logic [ROW_BITS-1:0]   sx_nxt;
   logic [COL_BITS-1:0]   sy_nxt;
   logic [SCALE_BITS-1:0] sc_nxt;
   logic [XW-1:0]         x_adv;
   logic [YW-1:0]         y_adv;
   logic [SW-1:0]         s_adv;

   // Widened increments so the overhanging last batch of a row cannot wrap x
   assign x_adv = {1'b0, x_q} + XW'(CORES);
   assign y_adv = {1'b0, y_q} + YW'(1);
   assign s_adv = {1'b0, s_q} + SW'(1);

   // Next-state, scan position and command outputs
   always_comb begin
      state_nxt = state;
      x_nxt     = x_q;
      y_nxt     = y_q;
      s_nxt     = s_q;
      w_nxt     = w_q;
      h_nxt     = h_q;
      n_nxt     = n_q;
      abort_nxt = abort_q;
      start_nxt = 1'b0;
      exit_nxt  = 1'b0;
      sx_nxt    = rs_startX;
      sy_nxt    = rs_startY;
      sc_nxt    = rs_scale;
      case (state)
         IDLE: begin
            if (cmd_start) begin
               w_nxt     = img_width;
               h_nxt     = img_height;
               n_nxt     = num_scales;
               x_nxt     = '0;
               y_nxt     = '0;
               s_nxt     = '0;
               abort_nxt = 1'b0;
               if (img_width == '0 || img_height == '0 || num_scales == '0)
                  state_nxt = EXIT;
               else
                  state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // A start coinciding with abort still goes out; the abort is honoured from WAIT
            if (rs_ready) begin
               start_nxt = 1'b1;
               sx_nxt    = x_q;
               sy_nxt    = y_q;
               sc_nxt    = s_q;
               state_nxt = WAIT;
               if (cmd_abort) abort_nxt = 1'b1;
            end else if (cmd_abort) begin
               state_nxt = EXIT;
            end
         end
         WAIT: begin
            if (cmd_abort || abort_q) begin
               state_nxt = EXIT;
            end else begin
               state_nxt = ISSUE;
               if (x_adv >= {1'b0, w_q}) begin
                  x_nxt = '0;
                  if (y_adv >= {1'b0, h_q}) begin
                     y_nxt = '0;
                     if (s_adv >= {1'b0, n_q})
                        state_nxt = EXIT;
                     else
                        s_nxt = s_adv[SCALE_BITS-1:0];
                  end else begin
                     y_nxt = y_adv[COL_BITS-1:0];
                  end
               end else begin
                  x_nxt = x_adv[ROW_BITS-1:0];
               end
            end
         end
         EXIT: begin
            if (rs_ready) begin
               start_nxt = 1'b1;
               exit_nxt  = 1'b1;
               state_nxt = EXIT_WAIT;
            end
         end
         EXIT_WAIT: begin
            // Ignore ready while our own strobe is still out; resultStore has not reacted yet
            if (rs_ready && !rs_start) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, scan position and registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         s_q       <= '0;
         w_q       <= '0;
         h_q       <= '0;
         n_q       <= '0;
         abort_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rs_start  <= 1'b0;
         rs_exit   <= 1'b0;
         rs_startX <= '0;
         rs_startY <= '0;
         rs_scale  <= '0;
      end else begin
         state     <= state_nxt;
         x_q       <= x_nxt;
         y_q       <= y_nxt;
         s_q       <= s_nxt;
         w_q       <= w_nxt;
         h_q       <= h_nxt;
         n_q       <= n_nxt;
         abort_q   <= abort_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
         rs_start  <= start_nxt;
         rs_exit   <= exit_nxt;
         rs_startX <= sx_nxt;
         rs_startY <= sy_nxt;
         rs_scale  <= sc_nxt;
      end
   end

`ifdef SCAN_PERF_CNT_EN
   // Batch counter: cleared on an accepted start, counts non-exit strobes, saturates
   always_ff @(posedge clk) begin
      if (!resetn)
         batch_count <= '0;
      else if (state == IDLE && cmd_start)
         batch_count <= '0;
      else if (start_nxt && !exit_nxt && batch_count != 32'hFFFF_FFFF)
         batch_count <= batch_count + 32'd1;
   end
`endif

endmodule

// File: doc/window_scan_sequencer.md
WINDOW_SCAN_SEQUENCER -- requirements
Module: window_scan_sequencer

Interface
REQ-001 Parameter CORES, default 32: windows evaluated per batch; one batch is one resultStore start.
REQ-002 Parameter ROW_BITS, default 10: width of x coordinate and img_width.
REQ-003 Parameter COL_BITS, default 10: width of y coordinate and img_height.
REQ-004 Parameter SCALE_BITS, default 5: width of scale index and num_scales.
REQ-005 clk  in  1  clock; all logic on posedge clk.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 cmd_start  in  1  one-cycle pulse that begins a full scan.
REQ-008 cmd_abort  in  1  terminate the scan early; the exit marker is still emitted.
REQ-009 img_width  in  ROW_BITS  scan columns; sampled at cmd_start.
REQ-010 img_height  in  COL_BITS  scan rows; sampled at cmd_start.
REQ-011 num_scales  in  SCALE_BITS  scale count; sampled at cmd_start.
REQ-012 busy  out  1  high from the cycle after an accepted cmd_start until done.
REQ-013 done  out  1  one-cycle pulse when the scan is complete.
REQ-014 rs_ready  in  1  resultStore idle and able to accept a start.
REQ-015 rs_start, rs_exit  out  1 each  resultStore command strobes.
REQ-016 rs_startX, rs_startY, rs_scale  out  ROW_BITS/COL_BITS/SCALE_BITS  batch origin and scale.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, EXIT, EXIT_WAIT, DONE.
REQ-018 IDLE: cmd_start latches the dimensions, clears x/y/s and goes to ISSUE (or EXIT if any dimension is 0); cmd_start in any other state is ignored.
REQ-019 ISSUE: when rs_ready=1, assert rs_start=1 and rs_exit=0 for exactly one cycle with the current x/y/s on the coordinate outputs, then go to WAIT.
REQ-020 WAIT: hold one cycle so the rs_ready low-going edge is seen, then advance and go to ISSUE; never two rs_start pulses within 2 cycles.
REQ-021 Advance order: x+=CORES; if x+CORES>=img_width, x=0 and y++; if y wraps at img_height, y=0 and s++; if s reaches num_scales, go to EXIT.
REQ-022 The last batch of a row MAY overhang img_width; x SHALL NOT overflow ROW_BITS (compare in ROW_BITS+1).
REQ-023 EXIT: when rs_ready=1, pulse rs_start=1 and rs_exit=1 for one cycle, then go to EXIT_WAIT.
REQ-024 EXIT_WAIT: wait until rs_ready=1 again (marker flushed), then go to DONE.
REQ-025 DONE: pulse done for one cycle, then go to IDLE.
REQ-026 cmd_abort high in ISSUE or WAIT: go to EXIT next cycle with no further batch; a start pulse coinciding with cmd_abort is still issued.
REQ-027 rs_start is registered; coordinate outputs are stable whenever rs_start=1.
REQ-028 Total batches = ceil(img_width/CORES) * img_height * num_scales.

Reset
REQ-029 With resetn=0 at a clock edge: state=IDLE; busy, done, rs_start, rs_exit=0; coordinates=0; latched dimensions=0.
REQ-030 Reset mid-scan abandons the scan with no exit marker; the resultStore is reset by the same resetn.

Configuration
REQ-031 Macro SCAN_PERF_CNT_EN defined: adds output batch_count (32 bits), cleared at cmd_start, +1 per non-exit rs_start, saturating at max, held after done.
REQ-032 Macro SCAN_PERF_CNT_EN undefined: no batch_count port and no counter logic; all other behaviour is identical.

Verification
REQ-033 CORES=32, w=64, h=2, scales=1, rs_ready always 1 -> 4 starts (x,y)=(0,0),(32,0),(0,1),(32,1), then an exit start, then done.
REQ-034 w=40, h=1, scales=2 -> starts (0,0,s0),(32,0,s0),(0,0,s1),(32,0,s1), then exit; batch_count=4 when enabled.
REQ-035 rs_ready held low 10 cycles after the first start -> no start while low; the next start comes the cycle rs_ready returns.
REQ-036 w=0 -> no batch starts; exactly one exit start, then done.
REQ-037 cmd_abort after the 2nd start of a w=128, h=4 scan -> no 3rd batch; exit start, done; cmd_start while busy ignored.
REQ-038 resetn low during WAIT -> all outputs 0 the next cycle, state IDLE, no done pulse.
